// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared types and encodings for the multicycle MIPS controller
package mips_ctrl_pkg;

    // Controller states; FETCH is the reset state.
    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC,
        S_ALUWB,
        S_BRANCH,
        S_ADDIEX,
        S_ADDIWB,
        S_JUMP
    } state_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // Native 4-bit ALU operation codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // ALU B-operand select
    localparam logic [1:0] ASB_RT      = 2'b00;
    localparam logic [1:0] ASB_FOUR    = 2'b01;
    localparam logic [1:0] ASB_IMM     = 2'b10;
    localparam logic [1:0] ASB_IMM_SH2 = 2'b11;

    // PC source select
    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - R-type funct to ALU control decoder with legality flag
module alu_decoder
    import mips_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 4
) (
    input  logic [5:0]           funct,
    output logic [ALUCTRL_W-1:0] alu_control,
    output logic                 valid
);

    logic [3:0] code;

    // Map funct to the native ALU code; unknown functs report valid=0 and code 0.
    always_comb begin
        code  = 4'b0000;
        valid = 1'b1;
        case (funct)
            FN_ADD:  code = ALU_ADD;
            FN_SUB:  code = ALU_SUB;
            FN_AND:  code = ALU_AND;
            FN_OR:   code = ALU_OR;
            FN_SLT:  code = ALU_SLT;
            default: valid = 1'b0;
        endcase
    end

    assign alu_control = ALUCTRL_W'(code);

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS main controller FSM (optional BNE via MULTICYCLE_CTRL_BNE_EN)
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [5:0]           op,
    input  logic [5:0]           funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 iord,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 reg_dst,
    output logic                 mem_to_reg,
    output logic                 reg_write,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [ALUCTRL_W-1:0] alu_control,
    output logic [1:0]           pc_src,
    output logic                 pc_en,
    output logic                 illegal_op,
    output logic                 instr_done
);

    localparam logic [ALUCTRL_W-1:0] ALU_ADD_W = ALUCTRL_W'(ALU_ADD);
    localparam logic [ALUCTRL_W-1:0] ALU_SUB_W = ALUCTRL_W'(ALU_SUB);

    state_t                 state;
    state_t                 next_state;
    logic [ALUCTRL_W-1:0]   dec_alu;
    logic                   dec_valid;
    logic                   branch_take;

    alu_decoder #(
        .ALUCTRL_W (ALUCTRL_W)
    ) u_alu_decoder (
        .funct       (funct),
        .alu_control (dec_alu),
        .valid       (dec_valid)
    );

`ifdef MULTICYCLE_CTRL_BNE_EN
    logic ne;

    // Remember whether the decoded branch is BNE so BRANCH can invert the zero test.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ne <= 1'b0;
        end else if (state == S_DECODE) begin
            ne <= (op == OP_BNE);
        end
    end

    assign branch_take = ne ? ~zero : zero;
`else
    assign branch_take = zero;
`endif

    // State register; reset parks the controller in FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and output decode; everything is forced low while reset is held.
    always_comb begin
        next_state  = state;
        mem_req     = 1'b0;
        iord        = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = ASB_RT;
        alu_control = '0;
        pc_src      = PC_ALU;
        pc_en       = 1'b0;
        illegal_op  = 1'b0;
        instr_done  = 1'b0;

        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    mem_req     = 1'b1;
                    alu_src_b   = ASB_FOUR;
                    alu_control = ALU_ADD_W;
                    pc_src      = PC_ALU;
                    if (mem_ready) begin
                        ir_write   = 1'b1;
                        pc_en      = 1'b1;
                        next_state = S_DECODE;
                    end
                end
                S_DECODE: begin
                    alu_src_b   = ASB_IMM_SH2;
                    alu_control = ALU_ADD_W;
                    case (op)
                        OP_LW, OP_SW: next_state = S_MEMADR;
                        OP_RTYPE:     next_state = S_EXEC;
                        OP_BEQ:       next_state = S_BRANCH;
`ifdef MULTICYCLE_CTRL_BNE_EN
                        OP_BNE:       next_state = S_BRANCH;
`endif
                        OP_ADDI:      next_state = S_ADDIEX;
                        OP_J:         next_state = S_JUMP;
                        default: begin
                            illegal_op = 1'b1;
                            next_state = S_FETCH;
                        end
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a   = 1'b1;
                    alu_src_b   = ASB_IMM;
                    alu_control = ALU_ADD_W;
                    next_state  = (op == OP_SW) ? S_MEMWR : S_MEMRD;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    if (mem_ready) begin
                        next_state = S_MEMWB;
                    end
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                    next_state = S_FETCH;
                end
                S_MEMWR: begin
                    mem_req   = 1'b1;
                    iord      = 1'b1;
                    mem_write = 1'b1;
                    if (mem_ready) begin
                        instr_done = 1'b1;
                        next_state = S_FETCH;
                    end
                end
                S_EXEC: begin
                    alu_src_a   = 1'b1;
                    alu_src_b   = ASB_RT;
                    alu_control = dec_alu;
                    if (dec_valid) begin
                        next_state = S_ALUWB;
                    end else begin
                        illegal_op = 1'b1;
                        next_state = S_FETCH;
                    end
                end
                S_ALUWB: begin
                    reg_write  = 1'b1;
                    reg_dst    = 1'b1;
                    instr_done = 1'b1;
                    next_state = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a   = 1'b1;
                    alu_src_b   = ASB_RT;
                    alu_control = ALU_SUB_W;
                    pc_src      = PC_ALUOUT;
                    pc_en       = branch_take;
                    instr_done  = 1'b1;
                    next_state  = S_FETCH;
                end
                S_ADDIEX: begin
                    alu_src_a   = 1'b1;
                    alu_src_b   = ASB_IMM;
                    alu_control = ALU_ADD_W;
                    next_state  = S_ADDIWB;
                end
                S_ADDIWB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                    next_state = S_FETCH;
                end
                S_JUMP: begin
                    pc_src     = PC_JUMP;
                    pc_en      = 1'b1;
                    instr_done = 1'b1;
                    next_state = S_FETCH;
                end
                default: next_state = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_control;
    logic [1:0] pc_src;
    logic       pc_en, illegal_op, instr_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multicycle_control #(.ALUCTRL_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op          (op),
        .funct       (funct),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .iord        (iord),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_control (alu_control),
        .pc_src      (pc_src),
        .pc_en       (pc_en),
        .illegal_op  (illegal_op),
        .instr_done  (instr_done)
    );

    logic [18:0] obs;
    assign obs = {mem_req, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                  alu_src_a, alu_src_b, alu_control, pc_src, pc_en, illegal_op, instr_done};

    localparam logic [18:0] ALL    = 19'h7FFFF;
    localparam logic [18:0] NO_ALU = 19'h7FE1F;

    typedef struct {
        bit          mr;
        logic [18:0] exp;
        logic [18:0] mask;
    } step_t;

    step_t q[$];

    function automatic logic [18:0] ov(input bit mreq, input bit io, input bit mw, input bit irw,
                                       input bit rdst, input bit m2r, input bit rw, input bit asa,
                                       input bit [1:0] asb, input bit [3:0] alu, input bit [1:0] pcs,
                                       input bit pce, input bit ill, input bit done);
        return {mreq, io, mw, irw, rdst, m2r, rw, asa, asb, alu, pcs, pce, ill, done};
    endfunction

    task automatic push(input bit mr, input logic [18:0] e, input logic [18:0] m);
        step_t s;
        s.mr = mr; s.exp = e; s.mask = m;
        q.push_back(s);
    endtask

    task automatic chk(input string tag, input logic [18:0] o, input logic [18:0] e, input logic [18:0] m);
        total++;
        assert ((o & m) === (e & m))
        else begin
            bad++;
            $error("FAIL %s: observed=%05h expected=%05h", tag, o & m, e & m);
        end
    endtask

    // Reference model: expected per-cycle outputs for one instruction, derived from
    // the instruction's class, the zero flag and the number of memory wait cycles.
    task automatic build(input logic [5:0] o, input logic [5:0] f, input bit z, input int fs, input int ms);
        int       kind;
        bit       fv;
        bit [3:0] fa;
        bit       fn_list_hit;
        bit [5:0] fns [5]  = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
        bit [3:0] codes [5] = '{4'd2, 4'd6, 4'd0, 4'd1, 4'd7};
        q.delete();
        case (o)
            6'd35: kind = 1;
            6'd43: kind = 2;
            6'd0:  kind = 3;
            6'd4:  kind = 4;
`ifdef MULTICYCLE_CTRL_BNE_EN
            6'd5:  kind = 5;
`endif
            6'd8:  kind = 6;
            6'd2:  kind = 7;
            default: kind = 0;
        endcase
        fv = 0; fa = 0; fn_list_hit = 0;
        for (int i = 0; i < 5; i++) if (fns[i] == f) begin fv = 1; fa = codes[i]; fn_list_hit = 1; end
        repeat (fs) push(0, ov(1,0,0,0,0,0,0,0,2'b01,4'd2,2'b00,0,0,0), ALL);
        push(1, ov(1,0,0,1,0,0,0,0,2'b01,4'd2,2'b00,1,0,0), ALL);
        push(1'($urandom), ov(0,0,0,0,0,0,0,0,2'b11,4'd2,2'b00,0,kind == 0,0), ALL);
        case (kind)
            1: begin
                push(1'($urandom), ov(0,0,0,0,0,0,0,1,2'b10,4'd2,2'b00,0,0,0), ALL);
                repeat (ms) push(0, ov(1,1,0,0,0,0,0,0,2'b00,4'd0,2'b00,0,0,0), ALL);
                push(1, ov(1,1,0,0,0,0,0,0,2'b00,4'd0,2'b00,0,0,0), ALL);
                push(1'($urandom), ov(0,0,0,0,0,1,1,0,2'b00,4'd0,2'b00,0,0,1), ALL);
            end
            2: begin
                push(1'($urandom), ov(0,0,0,0,0,0,0,1,2'b10,4'd2,2'b00,0,0,0), ALL);
                repeat (ms) push(0, ov(1,1,1,0,0,0,0,0,2'b00,4'd0,2'b00,0,0,0), ALL);
                push(1, ov(1,1,1,0,0,0,0,0,2'b00,4'd0,2'b00,0,0,1), ALL);
            end
            3: begin
                push(1'($urandom), ov(0,0,0,0,0,0,0,1,2'b00,fa,2'b00,0,!fv,0), fn_list_hit ? ALL : NO_ALU);
                if (fv) push(1'($urandom), ov(0,0,0,0,1,0,1,0,2'b00,4'd0,2'b00,0,0,1), ALL);
            end
            4: push(1'($urandom), ov(0,0,0,0,0,0,0,1,2'b00,4'd6,2'b01,z,0,1), ALL);
            5: push(1'($urandom), ov(0,0,0,0,0,0,0,1,2'b00,4'd6,2'b01,!z,0,1), ALL);
            6: begin
                push(1'($urandom), ov(0,0,0,0,0,0,0,1,2'b10,4'd2,2'b00,0,0,0), ALL);
                push(1'($urandom), ov(0,0,0,0,0,0,1,0,2'b00,4'd0,2'b00,0,0,1), ALL);
            end
            7: push(1'($urandom), ov(0,0,0,0,0,0,0,0,2'b00,4'd0,2'b10,1,0,1), ALL);
            default: ;
        endcase
    endtask

    // Drive the queued cycles; stop after checking cycle abort_at (if >= 0), mid-cycle.
    task automatic run(input string tag, input logic [5:0] o, input logic [5:0] f, input bit z,
                       input int fs, input int ms, input int abort_at);
        build(o, f, z, fs, ms);
        op = o; funct = f; zero = z;
        foreach (q[i]) begin
            mem_ready = q[i].mr;
            @(negedge clk);
            chk($sformatf("%s_c%0d", tag, i), obs, q[i].exp, q[i].mask);
            if (i == abort_at) return;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_now(input string tag);
        #2 rst_n = 1'b0;
        #1;
        chk({tag, "_memwr_drop"}, {18'd0, mem_write}, 19'd0, ALL);
        chk({tag, "_all_zero"}, obs, 19'd0, ALL);
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, "_held"}, obs, 19'd0, ALL);
        mem_ready = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [5:0] ops [8] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd5, 6'd8, 6'd2, 6'd63};
        logic [5:0] fnl [6] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd0};
        logic [5:0] ro, rf;

        rst_n = 1'b0; op = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
        #3;
        chk("reset_out", obs, 19'd0, ALL);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_held_ready", obs, 19'd0, ALL);
        rst_n = 1'b1;

        run("add",      6'd0,  6'd32, 0, 0, 0, -1);
        run("lw_st2",   6'd35, 6'd0,  0, 0, 2, -1);
        run("beq_z1",   6'd4,  6'd0,  1, 0, 0, -1);
        run("beq_z0",   6'd4,  6'd0,  0, 0, 0, -1);
        run("illegal",  6'd63, 6'd0,  0, 0, 0, -1);
        run("bne_z0",   6'd5,  6'd0,  0, 0, 0, -1);
        run("bne_z1",   6'd5,  6'd0,  1, 0, 0, -1);
        run("sw",       6'd43, 6'd0,  0, 1, 2, -1);
        run("addi",     6'd8,  6'd0,  0, 0, 0, -1);
        run("j",        6'd2,  6'd0,  0, 3, 0, -1);
        run("rbadfn",   6'd0,  6'd17, 0, 0, 0, -1);
        run("sub",      6'd0,  6'd34, 0, 0, 0, -1);
        run("slt",      6'd0,  6'd42, 0, 0, 0, -1);

        // Reset in the second MEMWR wait cycle of a store.
        run("sw_abort", 6'd43, 6'd0,  0, 0, 3, 4);
        reset_now("rst_memwr");
        run("after_rst", 6'd0, 6'd36, 0, 1, 0, -1);

        // Reset while a load waits in MEMRD.
        run("lw_abort", 6'd35, 6'd0,  0, 0, 3, 3);
        reset_now("rst_memrd");
        run("after_rst2", 6'd35, 6'd0, 1, 0, 1, -1);

        for (int n = 0; n < 200; n++) begin
            ro = ops[$urandom_range(0, 7)];
            if ($urandom_range(0, 9) == 0) ro = 6'($urandom);
            rf = fnl[$urandom_range(0, 5)];
            if ($urandom_range(0, 7) == 0) rf = 6'($urandom);
            run($sformatf("rnd%0d", n), ro, rf, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
